systemizer_host: RTL and testbench

SYSTEMIZER_HOST -- requirements
Module: systemizer_host

---
 rtl/systemizer_host_pkg.sv | 30 +++
 rtl/systemizer_host_if.sv | 37 +++
 rtl/systemizer_host_addr_ctr.sv | 30 +++
 rtl/systemizer_host.sv | 159 +++++++++++++++
 tb/tb_systemizer_host.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/systemizer_host_pkg.sv
// Shared types and default sizing for the systemizer host controller.
package systemizer_host_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_W    = 5;
    localparam int DEF_DEPTH     = 32;
    localparam int DEF_TIMEOUT_W = 16;

    typedef enum logic [2:0] {
        LOAD,
        START,
        WAIT,
        RD_REQ,
        RD_CAP,
        RD_OUT
    } state_e;

    typedef enum logic [1:0] {
        STAT_NONE    = 2'b00,
        STAT_OK      = 2'b01,
        STAT_FAIL    = 2'b10,
        STAT_TIMEOUT = 2'b11
    } status_e;

    // Any completion that is not flagged successful is reported as a failure.
    function automatic status_e done_status(input logic success);
        return success ? STAT_OK : STAT_FAIL;
    endfunction

endpackage

// File: rtl/systemizer_host_if.sv
// Host stream, status and systemizer memory/control signals of the host block.
interface systemizer_host_if #(
    parameter int DATA_W = systemizer_host_pkg::DEF_DATA_W,
    parameter int ADDR_W = systemizer_host_pkg::DEF_ADDR_W
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        status;
    logic              busy;
    logic              sys_wr_en;
    logic [ADDR_W-1:0] sys_wr_addr;
    logic [DATA_W-1:0] sys_data_in;
    logic              sys_rd_en;
    logic [ADDR_W-1:0] sys_rd_addr;
    logic [DATA_W-1:0] sys_data_out;
    logic              sys_start;
    logic              sys_done;
    logic              sys_fail;
    logic              sys_success;

    modport slave (
        input  in_data, in_valid, out_ready, sys_data_out, sys_done, sys_fail, sys_success,
        output in_ready, out_data, out_valid, status, busy,
               sys_wr_en, sys_wr_addr, sys_data_in, sys_rd_en, sys_rd_addr, sys_start
    );

    modport master (
        output in_data, in_valid, out_ready, sys_data_out, sys_done, sys_fail, sys_success,
        input  in_ready, out_data, out_valid, status, busy,
               sys_wr_en, sys_wr_addr, sys_data_in, sys_rd_en, sys_rd_addr, sys_start
    );

endinterface

// File: rtl/systemizer_host_addr_ctr.sv
// Shared load/unload word address counter with clear, increment and last-word flag.
module host_addr_ctr import systemizer_host_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LAST   = DEF_DEPTH - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_addr;

    // NOTE: state updates use <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (i_clr) begin
            r_addr <= '0;
        end else if (i_inc) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_addr == ADDR_W'(LAST));

endmodule

// File: rtl/systemizer_host.sv
// Loads DEPTH words into the systemizer, starts it, waits for completion under a
// watchdog, then streams the DEPTH result words back to the host.
module systemizer_host import systemizer_host_pkg::*; #(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int TIMEOUT_W = DEF_TIMEOUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    systemizer_host_if.slave bus
);

    // Compared before the increment, so expiry lands on the cycle the watchdog reaches all-ones.
    localparam logic [TIMEOUT_W-1:0] WD_EXPIRE = ~TIMEOUT_W'(1);

    state_e                r_state;
    state_e                w_state_next;
    status_e               r_status;
    status_e               w_status_next;
    logic [TIMEOUT_W-1:0]  r_wd;
    logic [DATA_W-1:0]     r_out_data;

    logic [ADDR_W-1:0]     w_addr;
    logic                  w_addr_last;
    logic                  w_addr_clr;
    logic                  w_addr_inc;
    logic                  w_in_ready;
    logic                  w_wr_en;
    logic                  w_start;
    logic                  w_rd_en;
    logic                  w_out_valid;
    logic                  w_capture;
    logic                  w_wd_clr;
    logic                  w_wd_inc;
    logic                  w_unused_fail;

    // A completion without sys_success already reads as a failure, so sys_fail adds nothing.
    assign w_unused_fail = bus.sys_fail;

    host_addr_ctr #(
        .ADDR_W (ADDR_W),
        .LAST   (DEPTH - 1)
    ) u_addr_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_addr_clr),
        .i_inc  (w_addr_inc),
        .o_addr (w_addr),
        .o_last (w_addr_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= LOAD;
            r_status   <= STAT_NONE;
            r_wd       <= '0;
            r_out_data <= '0;
        end else begin
            r_state  <= w_state_next;
            r_status <= w_status_next;
            if (w_wd_clr) begin
                r_wd <= '0;
            end else if (w_wd_inc) begin
                r_wd <= r_wd + 1'b1;
            end
            if (w_capture) begin
                r_out_data <= bus.sys_data_out;
            end
        end
    end

    // NOTE: every comb output gets a default first, so no path through the case leaves a latch.
    always_comb begin
        w_state_next  = r_state;
        w_status_next = r_status;
        w_addr_clr    = 1'b0;
        w_addr_inc    = 1'b0;
        w_in_ready    = 1'b0;
        w_wr_en       = 1'b0;
        w_start       = 1'b0;
        w_rd_en       = 1'b0;
        w_out_valid   = 1'b0;
        w_capture     = 1'b0;
        w_wd_clr      = 1'b0;
        w_wd_inc      = 1'b0;

        case (r_state)
            LOAD: begin
                // Gated by rst_n so in_ready rises only once reset is released.
                w_in_ready = rst_n;
                if (bus.in_valid && rst_n) begin
                    w_wr_en = 1'b1;
                    if (w_addr == '0) begin
                        w_status_next = STAT_NONE;
                    end
                    if (w_addr_last) begin
                        w_addr_clr   = 1'b1;
                        w_state_next = START;
                    end else begin
                        w_addr_inc = 1'b1;
                    end
                end
            end
            START: begin
                w_start      = 1'b1;
                w_wd_clr     = 1'b1;
                w_state_next = WAIT;
            end
            WAIT: begin
                w_wd_inc = 1'b1;
                if (bus.sys_done) begin
                    w_status_next = done_status(bus.sys_success);
                    w_state_next  = RD_REQ;
                end else if (r_wd == WD_EXPIRE) begin
                    w_status_next = STAT_TIMEOUT;
                    w_addr_clr    = 1'b1;
                    w_state_next  = LOAD;
                end
            end
            RD_REQ: begin
                w_rd_en      = 1'b1;
                w_state_next = RD_CAP;
            end
            RD_CAP: begin
                w_capture    = 1'b1;
                w_state_next = RD_OUT;
            end
            RD_OUT: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    if (w_addr_last) begin
                        w_addr_clr   = 1'b1;
                        w_state_next = LOAD;
                    end else begin
                        w_addr_inc   = 1'b1;
                        w_state_next = RD_REQ;
                    end
                end
            end
            default: begin
                w_state_next = LOAD;
            end
        endcase
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.sys_wr_en   = w_wr_en;
    assign bus.sys_wr_addr = w_addr;
    assign bus.sys_data_in = w_wr_en ? bus.in_data : '0;
    assign bus.sys_rd_en   = w_rd_en;
    assign bus.sys_rd_addr = w_addr;
    assign bus.sys_start   = w_start;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_data    = r_out_data;
    assign bus.status      = r_status;
    assign bus.busy        = !((r_state == LOAD) && (w_addr == '0));

endmodule

// File: tb/tb_systemizer_host.sv
// Self-checking bench: table-driven runs plus randomized runs against a run-level model.
module tb_systemizer_host;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 5;
    localparam int DEPTH     = 32;
    localparam int TIMEOUT_W = 4;
    localparam int WD_LIMIT  = (1 << TIMEOUT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    systemizer_host_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    systemizer_host #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .TIMEOUT_W (TIMEOUT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string    name;
        int       done_at;
        bit       succ;
        bit       fl;
        bit       rnd;
        bit       ramp;
        logic [1:0] exp_status;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Systemizer memory model and run observations
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] got_q [$];
    int   cyc = 0, wait_n = 0, done_at = 0;
    bit   done_succ, done_fail, acc_in, prev_hold;
    logic [DATA_W-1:0] prev_data;
    logic [1:0] obs_status, last_status = 2'b00;
    bit   obs_busy;
    int   n_wr, n_wr_err, n_start, n_rd, n_rd_err, n_stab_err;
    int   start_cyc, first_rd_cyc, to_cyc, first_out_cyc, last_out_cyc, last_acc_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] model_status(input int d, input bit s);
        if (d >= 1 && d <= WD_LIMIT) return s ? 2'b01 : 2'b10;
        return 2'b11;
    endfunction

    // Observe at negedge, then drive systemizer-side inputs just after the next posedge.
    task automatic tick();
        bit rd_now, start_now, fire;
        logic [ADDR_W-1:0] rd_a;
        @(negedge clk);
        cyc++;
        acc_in     = bus.in_valid && bus.in_ready;
        obs_status = bus.status;
        obs_busy   = bus.busy;
        if (bus.sys_wr_en !== acc_in) n_wr_err++;
        if (bus.sys_wr_en) begin
            if (bus.sys_wr_addr != ADDR_W'(n_wr)) n_wr_err++;
            mem[bus.sys_wr_addr] = bus.sys_data_in;
            n_wr++;
        end
        if (bus.sys_start) begin
            n_start++;
            start_cyc = cyc;
        end
        if (bus.sys_rd_en) begin
            if (bus.sys_rd_addr != ADDR_W'(n_rd)) n_rd_err++;
            if (n_rd == 0) first_rd_cyc = cyc;
            n_rd++;
        end
        if (prev_hold && (!bus.out_valid || bus.out_data !== prev_data)) n_stab_err++;
        prev_hold = bus.out_valid && !bus.out_ready;
        prev_data = bus.out_data;
        if (bus.out_valid && bus.out_ready) begin
            got_q.push_back(bus.out_data);
            if (got_q.size() == 1) first_out_cyc = cyc;
            last_out_cyc = cyc;
        end
        if (bus.status == 2'b11 && to_cyc < 0) to_cyc = cyc;
        rd_now    = bus.sys_rd_en;
        rd_a      = bus.sys_rd_addr;
        start_now = bus.sys_start;
        @(posedge clk);
        #1;
        bus.sys_data_out = rd_now ? (mem[rd_a] ^ 8'hA5) : 8'h00;
        if (start_now) wait_n = 1;
        else if (wait_n > 0) wait_n++;
        fire = (wait_n > 0) && (wait_n == done_at);
        bus.sys_done    = fire;
        bus.sys_success = fire && done_succ;
        bus.sys_fail    = fire && done_fail;
    endtask

    task automatic do_run(input string tag, input int d_at, input bit succ, input bit fl,
                          input bit rnd, input bit ramp, input logic [1:0] exp_status,
                          input int abort_at);
        logic [DATA_W-1:0] sent_q [$];
        logic [DATA_W-1:0] word;
        int budget, bad;
        bit chk_clear;
        n_wr = 0; n_wr_err = 0; n_start = 0; n_rd = 0; n_rd_err = 0; n_stab_err = 0;
        start_cyc = -1; first_rd_cyc = -1; to_cyc = -1; last_acc_cyc = -1;
        got_q.delete();
        done_at = d_at; done_succ = succ; done_fail = fl;
        chk_clear = 1'b0;
        word = ramp ? 8'h00 : 8'($urandom);
        budget = 0;
        while (sent_q.size() < DEPTH && budget < 400) begin
            bus.in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.in_data  = word;
            tick();
            budget++;
            if (chk_clear) begin
                check({tag, " status cleared"}, obs_status, 2'b00);
                chk_clear = 1'b0;
            end
            if (acc_in) begin
                if (sent_q.size() == 0) begin
                    check({tag, " status held"}, obs_status, last_status);
                    chk_clear = 1'b1;
                end
                sent_q.push_back(word);
                last_acc_cyc = cyc;
                word = ramp ? 8'(sent_q.size()) : 8'($urandom);
            end
        end
        bus.in_valid = 1'b0;
        budget = 0;
        while (budget < 600) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            budget++;
            if (abort_at > 0 && got_q.size() >= abort_at) return;
            if (exp_status == 2'b11 ? (to_cyc >= 0 && cyc >= to_cyc + 4)
                                    : (got_q.size() >= DEPTH)) break;
        end
        bus.out_ready = 1'b0;
        tick();
        check({tag, " wr count"}, n_wr, DEPTH);
        check({tag, " wr addr/handshake errs"}, n_wr_err, 0);
        check({tag, " start pulses"}, n_start, 1);
        check({tag, " start after last wr"}, start_cyc - last_acc_cyc, 1);
        check({tag, " status"}, obs_status, exp_status);
        check({tag, " busy idle"}, obs_busy, 1'b0);
        if (exp_status == 2'b11) begin
            check({tag, " timeout latency"}, to_cyc - start_cyc, WD_LIMIT + 1);
            check({tag, " no rd"}, n_rd, 0);
            check({tag, " no out"}, got_q.size(), 0);
        end else begin
            check({tag, " done latency"}, first_rd_cyc - start_cyc, d_at + 1);
            check({tag, " rd count"}, n_rd, DEPTH);
            check({tag, " rd addr errs"}, n_rd_err, 0);
            check({tag, " out count"}, got_q.size(), DEPTH);
            bad = 0;
            for (int i = 0; i < DEPTH; i++)
                if (i >= got_q.size() || got_q[i] !== (sent_q[i] ^ 8'hA5)) bad++;
            check({tag, " out words"}, bad, 0);
            check({tag, " out stable"}, n_stab_err, 0);
            if (!rnd) check({tag, " throughput"}, last_out_cyc - first_out_cyc, 3 * (DEPTH - 1));
        end
        last_status = exp_status;
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{"ok_ramp",     5,  1'b1, 1'b0, 1'b0, 1'b1, 2'b01};
        vecs[1] = '{"fail_only",   5,  1'b0, 1'b1, 1'b0, 1'b1, 2'b10};
        vecs[2] = '{"timeout",     0,  1'b0, 1'b0, 1'b0, 1'b1, 2'b11};
        vecs[3] = '{"succ_and_fl", 3,  1'b1, 1'b1, 1'b0, 0,    2'b01};
        vecs[4] = '{"done_last",   15, 1'b0, 1'b0, 1'b0, 0,    2'b10};
        vecs[5] = '{"done_first",  1,  1'b1, 1'b0, 1'b1, 0,    2'b01};
        vecs[6] = '{"rand_ready",  9,  1'b1, 1'b0, 1'b1, 0,    2'b01};
        vecs[7] = '{"rand_fail",   7,  1'b0, 1'b1, 1'b1, 0,    2'b10};

        rst_n = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'h3C; bus.out_ready = 1'b0;
        bus.sys_data_out = '0; bus.sys_done = 1'b0; bus.sys_fail = 1'b0; bus.sys_success = 1'b0;
        prev_hold = 1'b0;
        #12;
        check("reset in_ready", bus.in_ready, 1'b0);
        check("reset wr_en", bus.sys_wr_en, 1'b0);
        check("reset busy", bus.busy, 1'b0);
        check("reset status", bus.status, 2'b00);
        check("reset out_data", bus.out_data, 8'h00);
        bus.in_valid = 1'b0;
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post-reset in_ready", bus.in_ready, 1'b1);
        check("post-reset busy", bus.busy, 1'b0);

        foreach (vecs[i])
            do_run(vecs[i].name, vecs[i].done_at, vecs[i].succ, vecs[i].fl,
                   vecs[i].rnd, vecs[i].ramp, vecs[i].exp_status, 0);

        for (int r = 0; r < 4; r++) begin
            int d;
            bit s, f;
            d = $urandom_range(1, WD_LIMIT + 2);
            s = 1'($urandom_range(0, 1));
            f = 1'($urandom_range(0, 1));
            do_run($sformatf("random%0d", r), d, s, f, 1'b1, 1'b0, model_status(d, s), 0);
        end

        // Reset during unload, at the tenth word
        do_run("rst_mid", 5, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 10);
        bus.in_valid = 1'b1; bus.in_data = 8'h5A; bus.out_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid-reset out_valid", bus.out_valid, 1'b0);
        check("mid-reset out_data", bus.out_data, 8'h00);
        check("mid-reset status", bus.status, 2'b00);
        check("mid-reset busy", bus.busy, 1'b0);
        check("mid-reset in_ready", bus.in_ready, 1'b0);
        check("mid-reset sys ctl", {bus.sys_wr_en, bus.sys_rd_en, bus.sys_start}, 3'b000);
        check("mid-reset sys buses", {bus.sys_data_in, bus.sys_wr_addr, bus.sys_rd_addr}, 18'h0);
        wait_n = 0; prev_hold = 1'b0; last_status = 2'b00;
        bus.sys_done = 1'b0; bus.sys_success = 1'b0; bus.sys_fail = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        n_start = 0; n_wr = 0;
        for (int i = 0; i < 5; i++) tick();
        check("after reset no start", n_start, 0);
        check("after reset no wr", n_wr, 0);
        check("after reset busy", obs_busy, 1'b0);
        do_run("after_rst", 5, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global timeout: got no finish, expected finish before 5ms");
        $fatal(1, "simulation time limit");
    end

endmodule
